// File: rtl/display_mode_ctrl_pkg.sv
// Shared encodings and constants for the watch/stopwatch/alarm display sequencer.
package display_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    S_WATCH = 2'b00,
    S_SW    = 2'b01,
    S_ALSET = 2'b10,
    S_RING  = 2'b11
  } mode_e;

  localparam logic [7:0] SEG_COM_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DATA_RST  = 8'h00;

  function automatic mode_e next_user_mode(input mode_e m);
    case (m)
      S_WATCH: return S_SW;
      S_SW:    return S_ALSET;
      default: return S_WATCH;
    endcase
  endfunction

endpackage

// File: rtl/display_mode_ctrl_if.sv
// Buttons, alarm level, per-function display sources and the panel outputs of the sequencer.
interface display_mode_ctrl_if;
  import display_mode_ctrl_pkg::*;

  logic       mode;
  logic       alarm_ack;
  logic       alarm_req;
  logic [7:0] watch_seg_data;
  logic [7:0] watch_seg_com;
  logic [7:0] sw_seg_data;
  logic [7:0] sw_seg_com;
  logic [7:0] alm_seg_data;
  logic [7:0] alm_seg_com;
  logic [7:0] seg_data;
  logic [7:0] seg_com;
  mode_e      state_m;
  logic       ringing;

  modport master (
    output mode, alarm_ack, alarm_req,
    output watch_seg_data, watch_seg_com, sw_seg_data, sw_seg_com, alm_seg_data, alm_seg_com,
    input  seg_data, seg_com, state_m, ringing
  );

  modport slave (
    input  mode, alarm_ack, alarm_req,
    input  watch_seg_data, watch_seg_com, sw_seg_data, sw_seg_com, alm_seg_data, alm_seg_com,
    output seg_data, seg_com, state_m, ringing
  );
endinterface

// File: rtl/display_mode_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, one-cycle rise pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      // Count consecutive samples that disagree with the current level; any agreement restarts.
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        cnt   <= '0;
        level <= sync_p1;
        rise  <= sync_p1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/display_mode_ctrl.sv
// Mode sequencer and 7-seg arbiter: user mode cycling, alarm RING pre-emption with blink and timeout.
module display_mode_ctrl
  import display_mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int RING_CYC     = 10000,
  parameter int BLINK_HALF   = 250
) (
  input logic                clk,
  input logic                rst,
  display_mode_ctrl_if.slave disp
);
  localparam int RCW = $clog2(RING_CYC + 1);
  localparam int BCW = $clog2(BLINK_HALF + 1);

  logic           mode_rise;
  logic           ack_rise;
  logic [1:0]     btn_level_unused;

  mode_e          state_q, state_d;
  mode_e          saved_q, saved_d;
  logic [RCW-1:0] ring_cnt_q, ring_cnt_d;
  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_on_q, blink_on_d;
  logic           alarm_req_p0;
  logic           alarm_edge;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (disp.mode),
    .level   (btn_level_unused[0]),
    .rise    (mode_rise)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ack_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (disp.alarm_ack),
    .level   (btn_level_unused[1]),
    .rise    (ack_rise)
  );

  assign alarm_edge   = disp.alarm_req & ~alarm_req_p0;
  assign disp.state_m = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WATCH;
      saved_q      <= S_WATCH;
      ring_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b0;
      alarm_req_p0 <= 1'b0;
      disp.ringing <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      ring_cnt_q   <= ring_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      alarm_req_p0 <= disp.alarm_req;
      disp.ringing <= (state_d == S_RING);
    end
  end

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    ring_cnt_d  = ring_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    case (state_q)
      S_WATCH, S_SW: begin
        // Alarm beats a coincident mode pulse; the mode pulse is simply lost.
        if (alarm_edge) begin
          state_d     = S_RING;
          saved_d     = state_q;
          ring_cnt_d  = RCW'(RING_CYC - 1);
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
        end else if (mode_rise) begin
          state_d = next_user_mode(state_q);
        end
      end
      S_ALSET: begin
        if (mode_rise) state_d = next_user_mode(state_q);
      end
      S_RING: begin
        if (ack_rise || (ring_cnt_q == '0)) state_d = saved_q;
        else                                ring_cnt_d = ring_cnt_q - RCW'(1);
        if (blink_cnt_q == BCW'(BLINK_HALF - 1)) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BCW'(1);
        end
      end
      default: state_d = S_WATCH;
    endcase
  end

  // Output register stage: one cycle behind state_m and the source inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp.seg_data <= SEG_DATA_RST;
      disp.seg_com  <= SEG_COM_BLANK;
    end else begin
      case (state_q)
        S_SW: begin
          disp.seg_data <= disp.sw_seg_data;
          disp.seg_com  <= disp.sw_seg_com;
        end
        S_ALSET: begin
          disp.seg_data <= disp.alm_seg_data;
          disp.seg_com  <= disp.alm_seg_com;
        end
        S_RING: begin
          if (blink_on_q) begin
            disp.seg_data <= disp.watch_seg_data;
            disp.seg_com  <= disp.watch_seg_com;
          end else begin
            disp.seg_com  <= SEG_COM_BLANK;
          end
        end
        default: begin
          disp.seg_data <= disp.watch_seg_data;
          disp.seg_com  <= disp.watch_seg_com;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_display_mode_ctrl.sv
// Bench for display_mode_ctrl: two instances (long and short RING timeout) against a cycle model.
module tb_display_mode_ctrl;
  localparam int D  = 20;
  localparam int BH = 250;

  logic clk = 1'b0;
  logic rst;
  logic mode_r, ack_r, alarm_r;
  logic [7:0] w_d, w_c, s_d, s_c, a_d, a_c;

  int n_checks = 0;
  int n_errors = 0;

  int         rcyc [2] = '{10000, 100};
  int         m_st [2];
  int         m_saved [2];
  int         m_age [2];
  logic [7:0] m_sd [2];
  logic [7:0] m_sc [2];
  logic       m_hist [2][D+2];
  logic       m_lvl [2];
  logic       m_rise [2];
  logic       m_alarm_prev;

  display_mode_ctrl_if bus_a();
  display_mode_ctrl_if bus_b();

  assign bus_a.mode = mode_r;            assign bus_b.mode = mode_r;
  assign bus_a.alarm_ack = ack_r;        assign bus_b.alarm_ack = ack_r;
  assign bus_a.alarm_req = alarm_r;      assign bus_b.alarm_req = alarm_r;
  assign bus_a.watch_seg_data = w_d;     assign bus_b.watch_seg_data = w_d;
  assign bus_a.watch_seg_com = w_c;      assign bus_b.watch_seg_com = w_c;
  assign bus_a.sw_seg_data = s_d;        assign bus_b.sw_seg_data = s_d;
  assign bus_a.sw_seg_com = s_c;         assign bus_b.sw_seg_com = s_c;
  assign bus_a.alm_seg_data = a_d;       assign bus_b.alm_seg_data = a_d;
  assign bus_a.alm_seg_com = a_c;        assign bus_b.alm_seg_com = a_c;

  display_mode_ctrl #(.DEBOUNCE_CYC(D), .RING_CYC(10000), .BLINK_HALF(BH)) u_dut_a (
    .clk(clk), .rst(rst), .disp(bus_a.slave));
  display_mode_ctrl #(.DEBOUNCE_CYC(D), .RING_CYC(100), .BLINK_HALF(BH)) u_dut_b (
    .clk(clk), .rst(rst), .disp(bus_b.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: debounced level flips once the last D synchronized samples all disagree with it.
  task automatic model_step();
    logic al_edge, cand, same;
    logic raw [2];
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_saved[i] = 0; m_age[i] = 0;
        m_sd[i] = 8'h00; m_sc[i] = 8'hFF;
        m_lvl[i] = 1'b0; m_rise[i] = 1'b0;
        for (int k = 0; k < D + 2; k++) m_hist[i][k] = 1'b0;
      end
      m_alarm_prev = 1'b0;
    end else begin
      al_edge = alarm_r && !m_alarm_prev;
      for (int i = 0; i < 2; i++) begin
        case (m_st[i])
          1: begin m_sd[i] = s_d; m_sc[i] = s_c; end
          2: begin m_sd[i] = a_d; m_sc[i] = a_c; end
          3: if (((m_age[i] / BH) % 2) == 0) begin m_sd[i] = w_d; m_sc[i] = w_c; end
             else m_sc[i] = 8'hFF;
          default: begin m_sd[i] = w_d; m_sc[i] = w_c; end
        endcase
        if (m_st[i] == 3) begin
          if (m_rise[1] || m_age[i] == rcyc[i] - 1) m_st[i] = m_saved[i];
          else m_age[i]++;
        end else if (m_st[i] < 2 && al_edge) begin
          m_saved[i] = m_st[i]; m_st[i] = 3; m_age[i] = 0;
        end else if (m_rise[0]) begin
          m_st[i] = (m_st[i] + 1) % 3;
        end
      end
      m_alarm_prev = alarm_r;
      raw[0] = mode_r; raw[1] = ack_r;
      for (int b = 0; b < 2; b++) begin
        for (int k = D + 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        m_hist[b][0] = raw[b];
        cand = m_hist[b][2];
        same = 1'b1;
        for (int k = 2; k < D + 2; k++) if (m_hist[b][k] != cand) same = 1'b0;
        m_rise[b] = 1'b0;
        if (same && cand != m_lvl[b]) begin
          m_lvl[b] = cand;
          m_rise[b] = cand;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("st_a", int'(bus_a.state_m), m_st[0]);
    chk("ring_a", int'(bus_a.ringing), int'(m_st[0] == 3));
    chk("sd_a", int'(bus_a.seg_data), int'(m_sd[0]));
    chk("sc_a", int'(bus_a.seg_com), int'(m_sc[0]));
    chk("st_b", int'(bus_b.state_m), m_st[1]);
    chk("ring_b", int'(bus_b.ringing), int'(m_st[1] == 3));
    chk("sd_b", int'(bus_b.seg_data), int'(m_sd[1]));
    chk("sc_b", int'(bus_b.seg_com), int'(m_sc[1]));
  end

  initial forever begin
    @(negedge clk);
    w_d = 8'($urandom); w_c = 8'($urandom);
    s_d = 8'($urandom); s_c = 8'($urandom);
    a_d = 8'($urandom); a_c = 8'($urandom);
  end

  task automatic wait_leave_a(input int prev, output int k);
    k = 0;
    while (int'(bus_a.state_m) == prev && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic press(input bit is_ack, input int prev, input int want, input string tag);
    int k;
    if (is_ack) ack_r = 1'b1; else mode_r = 1'b1;
    wait_leave_a(prev, k);
    chk({tag, "_lat"}, k, D + 3);
    chk({tag, "_st"}, int'(bus_a.state_m), want);
    repeat (40) @(negedge clk);
    ack_r = 1'b0; mode_r = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    int nb;
    rst = 1'b1;
    mode_r = 1'($urandom); ack_r = 1'($urandom); alarm_r = 1'($urandom);
    @(negedge clk);
    chk("rst_sc", int'(bus_a.seg_com), 8'hFF);
    chk("rst_sd", int'(bus_a.seg_data), 8'h00);
    chk("rst_st", int'(bus_a.state_m), 0);
    chk("rst_ring", int'(bus_a.ringing), 0);
    repeat (2) begin
      mode_r = 1'($urandom); ack_r = 1'($urandom); alarm_r = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; mode_r = 1'b0; ack_r = 1'b0; alarm_r = 1'b0;
    repeat (30) @(negedge clk);

    press(1'b0, 0, 1, "mode1");
    press(1'b0, 1, 2, "mode2");
    press(1'b0, 2, 0, "mode3");

    // Bouncing press: every high spell is shorter than the debounce window.
    for (int t = 0; t < 12; t++) begin
      mode_r = ~mode_r;
      repeat (5) @(negedge clk);
    end
    press(1'b0, 0, 1, "bounce");
    chk("bounce_once", int'(bus_a.state_m), 1);

    // Alarm from STOPWATCH: instance B times out after 100 cycles, A waits for ack.
    alarm_r = 1'b1;
    @(negedge clk);
    chk("alm_enter_a", int'(bus_a.state_m), 3);
    chk("alm_enter_b", int'(bus_b.state_m), 3);
    nb = 0;
    for (int j = 0; j < 1000; j++) begin
      if (int'(bus_b.state_m) == 3) nb++;
      if (j == 260) chk("blink_off", int'(bus_a.seg_com), 8'hFF);
      @(negedge clk);
    end
    chk("ring_b_len", nb, 100);
    chk("ret_b", int'(bus_b.state_m), 1);
    press(1'b1, 3, 1, "ack");
    alarm_r = 1'b0;
    repeat (5) @(negedge clk);

    // Mode pulse and alarm edge land on the same cycle.
    mode_r = 1'b1;
    repeat (22) @(negedge clk);
    alarm_r = 1'b1;
    @(negedge clk);
    chk("prio_a", int'(bus_a.state_m), 3);
    chk("prio_b", int'(bus_b.state_m), 3);
    repeat (40) @(negedge clk);
    mode_r = 1'b0;
    repeat (80) @(negedge clk);
    chk("prio_ret_b", int'(bus_b.state_m), 1);
    press(1'b1, 3, 1, "prio_ack");
    alarm_r = 1'b0;
    repeat (5) @(negedge clk);

    // Alarm edges are dropped while editing the alarm.
    press(1'b0, 1, 2, "to_alset");
    alarm_r = 1'b1;
    repeat (5) @(negedge clk);
    chk("alset_ign_a", int'(bus_a.state_m), 2);
    chk("alset_ign_b", int'(bus_b.state_m), 2);
    press(1'b0, 2, 0, "alset_exit");
    chk("no_queue", int'(bus_a.ringing), 0);
    alarm_r = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) mode_r = ~mode_r;
      if ($urandom_range(0, 39) == 0) ack_r = ~ack_r;
      if ($urandom_range(0, 149) == 0) alarm_r = ~alarm_r;
      rst = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end

    // Reset in the middle of RING.
    mode_r = 1'b0; ack_r = 1'b0; alarm_r = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    alarm_r = 1'b1;
    @(negedge clk);
    chk("mid_enter", int'(bus_a.state_m), 3);
    repeat (49) @(negedge clk);
    rst = 1'b1; alarm_r = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_st", int'(bus_a.state_m), 0);
    chk("mid_rst_ring", int'(bus_a.ringing), 0);
    repeat (60) @(negedge clk);
    chk("mid_no_pulse", int'(bus_a.state_m), 0);

    // Button held through reset gives one pulse afterwards.
    mode_r = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("held_rst", int'(bus_a.state_m), 1);
    mode_r = 1'b0;
    repeat (30) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
